// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types and default parameter values for the LED driver.
//   led_mode_t : per-channel operating mode, two bits per channel on mode_i
//   led_act_t  : state of the per-channel activity pulse-stretcher
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_ACT   = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_GAP  = 2'd2
  } led_act_t;

  localparam int unsigned MODE_W = 2;

  // Short tick period in simulation builds so blink/activity timing is reachable.
`ifdef SIMULATION
  localparam int unsigned TICK_DIV_DEF = 10;
`else
  localparam int unsigned TICK_DIV_DEF = 100_000;
`endif

endpackage

// File: rtl/led_channel.sv
// ---------------------------------------------------------------------------
// led_channel
// One LED channel: blink phase generator, activity pulse-stretch FSM, mode
// tracking and the registered LED output.
// Ports:
//   sys_clk, sys_rst  : clock, async active-high reset
//   i_tick            : shared prescaler tick (one-cycle pulse)
//   i_pcnt            : shared PWM counter
//   i_mode            : this channel's led_mode_t
//   i_bright          : PWM duty (0 = off, all-ones = fully on)
//   i_half_period     : blink half-period in ticks (0 treated as 1)
//   i_event           : activity event, sampled every cycle
//   i_phase_clr       : realign blink phase
//   o_led             : registered LED drive
// ---------------------------------------------------------------------------
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PW      = 10,
  parameter int unsigned BW      = 4,
  parameter int unsigned STRETCH = 50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  i_tick,
  input  logic [BW-1:0]         i_pcnt,
  input  logic [MODE_W-1:0]     i_mode,
  input  logic [BW-1:0]         i_bright,
  input  logic [PW-1:0]         i_half_period,
  input  logic                  i_event,
  input  logic                  i_phase_clr,
  output logic                  o_led
);

  localparam int unsigned AW = (STRETCH > 1) ? $clog2(STRETCH) : 1;

  led_mode_t      r_mode;   // previous-cycle mode; also selects the raw source
  logic [PW-1:0]  r_bcnt;
  logic           r_phase;
  logic [AW-1:0]  r_acnt;
  led_act_t       r_act;
  logic           r_pend;
  logic           r_led;

  led_mode_t      w_mode;
  logic           w_mode_chg;
  logic [PW-1:0]  w_hp_last;
  logic           w_acnt_end;
  logic           w_pwm;
  logic           w_raw;

  assign w_mode     = led_mode_t'(i_mode);
  assign w_mode_chg = (w_mode != r_mode);
  // Last bcnt value of a half-period; a zero half-period behaves as one tick.
  assign w_hp_last  = (i_half_period == '0) ? '0 : i_half_period - PW'(1);
  assign w_acnt_end = (r_acnt == AW'(STRETCH - 1));
  assign w_pwm      = (i_pcnt < i_bright);

  // Raw on/off level from the registered mode and channel state.
  always_comb begin
    w_raw = 1'b0;
    case (r_mode)
      LED_ON:    w_raw = 1'b1;
      LED_BLINK: w_raw = r_phase;
      LED_ACT:   w_raw = (r_act == ACT_ON);
      default:   w_raw = 1'b0;
    endcase
  end

  // Mode tracking, blink generator, activity FSM and output register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_mode  <= LED_OFF;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
      r_acnt  <= '0;
      r_act   <= ACT_IDLE;
      r_pend  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_mode <= w_mode;
      r_led  <= w_raw & w_pwm;

      // Blink: held cleared outside BLINK; phase_clr wins over a tick.
      if (w_mode_chg || (r_mode != LED_BLINK) || i_phase_clr) begin
        r_bcnt  <= '0;
        r_phase <= 1'b1;
      end else if (i_tick) begin
        // >= so a shrunken half-period wraps on the next tick.
        if (r_bcnt >= w_hp_last) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + PW'(1);
        end
      end

      // Activity pulse-stretcher: held cleared outside ACT.
      if (w_mode_chg || (r_mode != LED_ACT)) begin
        r_acnt <= '0;
        r_act  <= ACT_IDLE;
        r_pend <= 1'b0;
      end else begin
        case (r_act)
          ACT_IDLE: begin
            if (i_event) begin
              r_act  <= ACT_ON;
              r_acnt <= '0;
            end
          end
          ACT_ON: begin
            if (i_event) r_pend <= 1'b1;
            if (i_tick) begin
              if (w_acnt_end) begin
                r_act  <= ACT_GAP;
                r_acnt <= '0;
              end else begin
                r_acnt <= r_acnt + AW'(1);
              end
            end
          end
          ACT_GAP: begin
            if (i_tick && w_acnt_end) begin
              // An event on the closing cycle counts as pending.
              r_act  <= (r_pend || i_event) ? ACT_ON : ACT_IDLE;
              r_pend <= 1'b0;
              r_acnt <= '0;
            end else begin
              if (i_tick)  r_acnt <= r_acnt + AW'(1);
              if (i_event) r_pend <= 1'b1;
            end
          end
          default: begin
            r_act  <= ACT_IDLE;
            r_acnt <= '0;
            r_pend <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_ctrl.sv
// ---------------------------------------------------------------------------
// led_ctrl
// NLED-channel LED driver: off / on / blink / activity modes with per-channel
// PWM brightness and a shared tick prescaler.
// Ports:
//   sys_clk, sys_rst : clock, async active-high reset
//   mode_i           : per-channel led_mode_t, channel i at [2i+1:2i]
//   bright_i         : per-channel duty, channel i at [BW*i+BW-1:BW*i]
//   half_period_i    : blink half-period in ticks, shared (0 treated as 1)
//   event_i          : activity events, one per channel
//   phase_clr_i      : realign all blink channels
//   led_o            : registered LED drive
//   tick_o           : prescaler tick, one-cycle pulse
// ---------------------------------------------------------------------------
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NLED     = 8,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned PW       = 10,
  parameter int unsigned BW       = 4,
  parameter int unsigned STRETCH  = 50
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NLED*MODE_W-1:0] mode_i,
  input  logic [NLED*BW-1:0]     bright_i,
  input  logic [PW-1:0]          half_period_i,
  input  logic [NLED-1:0]        event_i,
  input  logic                   phase_clr_i,
  output logic [NLED-1:0]        led_o,
  output logic                   tick_o
);

  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PCNT_MAX = (1 << BW) - 2;

  logic [TW-1:0]   r_tcnt;
  logic            r_tick;
  logic [BW-1:0]   r_pcnt;
  logic            w_tcnt_end;
  logic [NLED-1:0] w_led;

  assign w_tcnt_end = (r_tcnt == TW'(TICK_DIV - 1));

  // Prescaler and PWM counter (period 2^BW-1 so full-scale duty is always on).
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
      r_pcnt <= '0;
    end else begin
      r_tick <= w_tcnt_end;
      r_tcnt <= w_tcnt_end ? '0 : r_tcnt + TW'(1);
      r_pcnt <= (r_pcnt == BW'(PCNT_MAX)) ? '0 : r_pcnt + BW'(1);
    end
  end

  for (genvar g = 0; g < NLED; g++) begin : g_ch
    led_channel #(
      .PW      (PW),
      .BW      (BW),
      .STRETCH (STRETCH)
    ) u_ch (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .i_tick        (r_tick),
      .i_pcnt        (r_pcnt),
      .i_mode        (mode_i[MODE_W*g +: MODE_W]),
      .i_bright      (bright_i[BW*g +: BW]),
      .i_half_period (half_period_i),
      .i_event       (event_i[g]),
      .i_phase_clr   (phase_clr_i),
      .o_led         (w_led[g])
    );
  end

  assign led_o  = w_led;
  assign tick_o = r_tick;

endmodule

// File: tb/tb_led_ctrl.sv
// Testbench for led_ctrl (TICK_DIV=10, BW=4, STRETCH=3, PW=4).
// Stimulus queues expected LED/tick values per cycle; a monitor compares them.
module tb_led_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] mode;
  logic [31:0] bright;
  logic [3:0]  hp;
  logic [7:0]  ev;
  logic        clr;
  logic [7:0]  led;
  logic        tick;

  led_ctrl #(
    .NLED     (8),
    .TICK_DIV (10),
    .PW       (4),
    .BW       (4),
    .STRETCH  (3)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .mode_i        (mode),
    .bright_i      (bright),
    .half_period_i (hp),
    .event_i       (ev),
    .phase_clr_i   (clr),
    .led_o         (led),
    .tick_o        (tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int gcyc = 0;
  int base = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge sys_clk) gcyc <= gcyc + 1;

  // Scoreboard: expected values keyed by absolute cycle.
  int         q_cyc[$];
  int         q_kind[$];  // 0 = led_o under mask, 1 = tick_o
  logic [7:0] q_mask[$];
  logic [7:0] q_val[$];
  string      q_name[$];

  task automatic exp_led(input int k, input logic [7:0] m, input logic [7:0] v, input string nm);
    q_cyc.push_back(base + k); q_kind.push_back(0);
    q_mask.push_back(m); q_val.push_back(v); q_name.push_back(nm);
  endtask

  task automatic exp_tick(input int k, input logic v, input string nm);
    q_cyc.push_back(base + k); q_kind.push_back(1);
    q_mask.push_back(8'h01); q_val.push_back({7'd0, v}); q_name.push_back(nm);
  endtask

  // Monitor: compare all entries due this cycle.
  always @(negedge sys_clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] <= gcyc) begin
        checks++;
        if (q_cyc[i] < gcyc) begin
          failures++;
          $display("FAIL %s missed cycle %0d", q_name[i], q_cyc[i]);
        end else if (q_kind[i] == 1) begin
          if (tick !== q_val[i][0]) begin
            failures++;
            $display("FAIL %s cyc=%0d tick_o=%b expected=%b", q_name[i], gcyc - base, tick, q_val[i][0]);
          end
        end else if ((led & q_mask[i]) !== q_val[i]) begin
          failures++;
          $display("FAIL %s cyc=%0d led_o&mask=%b expected=%b", q_name[i], gcyc - base, led & q_mask[i], q_val[i]);
        end
        q_cyc.delete(i); q_kind.delete(i); q_mask.delete(i);
        q_val.delete(i); q_name.delete(i);
      end
    end
  end

  task automatic at(input int k);
    while (gcyc < base + k) @(negedge sys_clk);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic set_bright(input int ch, input logic [3:0] b);
    bright[4*ch +: 4] = b;
  endtask

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ACT = 2'd3;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; mode = '0; bright = '0; hp = '0; ev = '0; clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    base = gcyc;

    // Reset state and prescaler
    exp_led(1, 8'hff, 8'h00, "rst_led");
    exp_led(5, 8'hff, 8'h00, "idle_led");
    exp_tick(1, 1'b0, "rst_tick");
    exp_tick(9, 1'b0, "tick9");
    exp_tick(10, 1'b1, "tick10");
    exp_tick(11, 1'b0, "tick11");
    exp_tick(20, 1'b1, "tick20");
    exp_tick(100, 1'b1, "tick100");
    exp_tick(101, 1'b0, "tick101");

    // PWM on ch0
    at(20); set_mode(0, M_ON); set_bright(0, 4'd0);
    for (int k = 23; k <= 37; k++) exp_led(k, 8'h01, 8'h00, "pwm0");
    at(40); set_bright(0, 4'd5);
    for (int k = 42; k <= 56; k++) exp_led(k, 8'h01, (((k - 1) % 15) < 5) ? 8'h01 : 8'h00, "pwm5");
    at(60); set_bright(0, 4'd15);
    for (int k = 62; k <= 76; k++) exp_led(k, 8'h01, 8'h01, "pwm15");
    at(80); set_mode(0, M_OFF);

    // Blink ch1, half_period=2 then 0
    at(100); set_mode(1, M_BLINK); set_bright(1, 4'd15); hp = 4'd2;
    exp_led(102, 8'h02, 8'h02, "blink_start");
    exp_led(121, 8'h02, 8'h02, "blink_121");
    exp_led(122, 8'h02, 8'h00, "blink_122");
    exp_led(141, 8'h02, 8'h00, "blink_141");
    exp_led(142, 8'h02, 8'h02, "blink_142");
    exp_led(161, 8'h02, 8'h02, "blink_161");
    exp_led(162, 8'h02, 8'h00, "blink_162");
    at(165); hp = 4'd0;
    exp_led(171, 8'h02, 8'h00, "hp0_171");
    exp_led(172, 8'h02, 8'h02, "hp0_172");
    exp_led(181, 8'h02, 8'h02, "hp0_181");
    exp_led(182, 8'h02, 8'h00, "hp0_182");
    exp_led(192, 8'h02, 8'h02, "hp0_192");

    // phase_clr aligns ch1/ch2, coinciding with a tick
    at(195); hp = 4'd2;
    at(205); set_mode(2, M_BLINK); set_bright(2, 4'd15);
    exp_led(235, 8'h06, 8'h02, "clr_before");
    exp_led(252, 8'h06, 8'h06, "clr_252");
    exp_led(262, 8'h06, 8'h06, "clr_262");
    exp_led(272, 8'h06, 8'h00, "clr_272");
    exp_led(292, 8'h06, 8'h06, "clr_292");
    at(250); clr = 1'b1;
    at(251); clr = 1'b0;
    at(295); set_mode(1, M_OFF); set_mode(2, M_OFF);

    // Activity: ch2 single pulses, ch3 continuous
    at(300); set_mode(2, M_ACT); set_mode(3, M_ACT); set_bright(3, 4'd15);
    exp_led(306, 8'h04, 8'h00, "act1_306");
    exp_led(307, 8'h04, 8'h04, "act1_307");
    exp_led(331, 8'h04, 8'h04, "act1_331");
    exp_led(332, 8'h04, 8'h00, "act1_332");
    exp_led(361, 8'h04, 8'h00, "act1_361");
    exp_led(362, 8'h04, 8'h04, "act1_362");
    exp_led(391, 8'h04, 8'h04, "act1_391");
    exp_led(392, 8'h04, 8'h00, "act1_392");
    exp_led(410, 8'h04, 8'h00, "act1_410");
    exp_led(421, 8'h04, 8'h00, "actgap_421");
    exp_led(422, 8'h04, 8'h04, "actgap_422");
    exp_led(451, 8'h04, 8'h04, "actgap_451");
    exp_led(452, 8'h04, 8'h00, "actgap_452");
    exp_led(490, 8'h04, 8'h00, "actgap_490");
    exp_led(304, 8'h08, 8'h00, "actc_304");
    exp_led(305, 8'h08, 8'h08, "actc_305");
    exp_led(331, 8'h08, 8'h08, "actc_331");
    exp_led(332, 8'h08, 8'h00, "actc_332");
    exp_led(361, 8'h08, 8'h00, "actc_361");
    exp_led(362, 8'h08, 8'h08, "actc_362");
    exp_led(391, 8'h08, 8'h08, "actc_391");
    exp_led(392, 8'h08, 8'h00, "actc_392");
    exp_led(421, 8'h08, 8'h00, "actc_421");
    exp_led(422, 8'h08, 8'h08, "actc_422");
    exp_led(451, 8'h08, 8'h08, "actc_451");
    exp_led(452, 8'h08, 8'h00, "actc_452");
    exp_led(482, 8'h08, 8'h08, "actc_482");
    at(303); ev[3] = 1'b1;
    at(305); ev[2] = 1'b1;
    at(306); ev[2] = 1'b0;
    at(315); ev[2] = 1'b1;
    at(316); ev[2] = 1'b0;
    at(420); ev[2] = 1'b1;
    at(421); ev[2] = 1'b0;

    // Mode switch ACT->BLINK during ON (ch3), and ON->OFF latency (ch4)
    at(485); set_mode(3, M_BLINK); ev[3] = 1'b0;
    exp_led(486, 8'h08, 8'h08, "sw_486");
    exp_led(487, 8'h08, 8'h08, "sw_487");
    exp_led(501, 8'h08, 8'h08, "sw_501");
    exp_led(502, 8'h08, 8'h00, "sw_502");
    at(500); set_mode(4, M_ON); set_bright(4, 4'd15);
    exp_led(501, 8'h10, 8'h00, "lat_501");
    exp_led(502, 8'h10, 8'h10, "lat_502");
    at(510); set_mode(3, M_ACT);
    exp_led(512, 8'h08, 8'h00, "sw_back_512");
    exp_led(540, 8'h08, 8'h00, "sw_back_540");
    at(520); set_mode(4, M_OFF);
    exp_led(521, 8'h10, 8'h10, "lat_521");
    exp_led(522, 8'h10, 8'h00, "lat_522");

    // Asynchronous reset mid-blink on ch0
    at(600); set_mode(0, M_BLINK); hp = 4'd2;
    exp_led(602, 8'h01, 8'h01, "preblink_602");
    exp_led(605, 8'h01, 8'h01, "preblink_605");
    at(605);
    exp_led(606, 8'hff, 8'h00, "rst_async_led");
    exp_tick(606, 1'b0, "rst_async_tick");
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    base = gcyc;
    exp_led(1, 8'hff, 8'h00, "rel_1");
    exp_led(2, 8'h01, 8'h01, "rel_2");
    exp_led(21, 8'h01, 8'h01, "rel_21");
    exp_led(22, 8'h01, 8'h00, "rel_22");
    exp_led(41, 8'h01, 8'h00, "rel_41");
    exp_led(42, 8'h01, 8'h01, "rel_42");
    exp_tick(10, 1'b1, "rel_tick10");

    at(50);
    for (int n = 0; n < 200 && q_cyc.size() > 0; n++) @(negedge sys_clk);
    if (q_cyc.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q_cyc.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
